johnson4_phase_decoder: RTL and testbench



---
 rtl/johnson_pkg.sv | 38 +++
 rtl/johnson_code_lookup.sv | 21 ++
 rtl/johnson4_phase_decoder.sv | 135 +++++++++++++
 tb/tb_johnson4_phase_decoder.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/johnson_pkg.sv
// Shared definitions for the 4-bit Johnson phase decoder.
//   state_t       : decoder FSM states
//   NUM_PHASES    : phases per revolution of a 4-bit Johnson counter
//   LEGAL_CODES   : Johnson code for each phase, indexed by phase
//   decode_code() : maps a 4-bit code to {valid, phase}
package johnson_pkg;

    typedef enum logic [1:0] {
        ST_ACQUIRE,
        ST_LOCKED,
        ST_FAULT
    } state_t;

    localparam int unsigned NUM_PHASES = 8;

    localparam logic [3:0] LEGAL_CODES [NUM_PHASES] = '{
        4'b0000, 4'b0001, 4'b0011, 4'b0111,
        4'b1111, 4'b1110, 4'b1100, 4'b1000
    };

    typedef struct packed {
        logic       valid;
        logic [2:0] phase;
    } code_info_t;

    function automatic code_info_t decode_code(input logic [3:0] code);
        code_info_t info;
        info = '0;
        for (int unsigned k = 0; k < NUM_PHASES; k++) begin
            if (code == LEGAL_CODES[k]) begin
                info.valid = 1'b1;
                info.phase = 3'(k);
            end
        end
        return info;
    endfunction

endpackage

// File: rtl/johnson_code_lookup.sv
// Combinational Johnson code classifier.
//   code  : 4-bit code from the upstream Johnson counter
//   valid : high when code is one of the 8 legal Johnson codes
//   phase : phase index 0..7 of a legal code (0 when illegal)
module johnson_code_lookup
    import johnson_pkg::*;
(
    input  logic [3:0] code,
    output logic       valid,
    output logic [2:0] phase
);

    code_info_t info;

    always_comb begin
        info  = decode_code(code);
        valid = info.valid;
        phase = info.phase;
    end

endmodule

// File: rtl/johnson4_phase_decoder.sv
// Johnson-counter phase decoder with lock tracking.
//   CLK    : clock, rising edge
//   RESET  : synchronous active-high reset, highest priority
//   I      : 4-bit Johnson code, sampled every cycle
//   O      : registered one-hot phase strobe, zero unless locked
//   PHASE  : registered phase index, holds last locked value
//   LOCKED : high while in the locked state
//   WRAP   : one-cycle pulse on a phase 7 -> 0 step
//   REVS   : revolution counter, wraps
//   FAULT  : high while in the fault state
//   ERRS   : saturating count of fault entries / illegal acquire codes
module johnson4_phase_decoder
    import johnson_pkg::*;
#(
    parameter int unsigned CNT_WIDTH  = 8,
    parameter int unsigned ERR_WIDTH  = 4,
    parameter bit          ALLOW_HOLD = 1'b1
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [3:0]           I,
    output logic [7:0]           O,
    output logic [2:0]           PHASE,
    output logic                 LOCKED,
    output logic                 WRAP,
    output logic [CNT_WIDTH-1:0] REVS,
    output logic                 FAULT,
    output logic [ERR_WIDTH-1:0] ERRS
);

    logic       code_valid;
    logic [2:0] code_phase;

    johnson_code_lookup u_lookup (
        .code  (I),
        .valid (code_valid),
        .phase (code_phase)
    );

    state_t                state_q, state_d;
    logic [2:0]            phase_q, phase_d;
    logic [7:0]            o_q, o_d;
    logic                  wrap_q, wrap_d;
    logic                  locked_q, locked_d;
    logic                  fault_q, fault_d;
    logic [CNT_WIDTH-1:0]  revs_q, revs_d;
    logic [ERR_WIDTH-1:0]  errs_q, errs_d;
    logic [ERR_WIDTH-1:0]  errs_inc;
    logic [2:0]            succ_phase;

    always_comb begin
        errs_inc   = (errs_q == '1) ? errs_q : errs_q + ERR_WIDTH'(1);
        succ_phase = phase_q + 3'd1;

        state_d = state_q;
        phase_d = phase_q;
        o_d     = o_q;
        wrap_d  = 1'b0;
        revs_d  = revs_q;
        errs_d  = errs_q;

        case (state_q)
            ST_ACQUIRE: begin
                if (code_valid) begin
                    state_d = ST_LOCKED;
                    phase_d = code_phase;
                    o_d     = 8'b1 << code_phase;
                end else begin
                    errs_d = errs_inc;
                end
            end
            ST_LOCKED: begin
                if (code_valid && code_phase == succ_phase) begin
                    phase_d = succ_phase;
                    o_d     = 8'b1 << succ_phase;
                    if (phase_q == 3'd7) begin
                        wrap_d = 1'b1;
                        revs_d = revs_q + CNT_WIDTH'(1);
                    end
                end else if (ALLOW_HOLD && code_valid && code_phase == phase_q) begin
                    // upstream clock-enabled hold: nothing moves
                end else begin
                    state_d = ST_FAULT;
                    o_d     = '0;
                    errs_d  = errs_inc;
                end
            end
            ST_FAULT: begin
                if (I == 4'b0000) begin
                    state_d = ST_LOCKED;
                    phase_d = 3'd0;
                    o_d     = 8'b0000_0001;
                end
            end
            default: begin
                state_d = ST_ACQUIRE;
                o_d     = '0;
            end
        endcase

        locked_d = (state_d == ST_LOCKED);
        fault_d  = (state_d == ST_FAULT);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= ST_ACQUIRE;
            phase_q  <= '0;
            o_q      <= '0;
            wrap_q   <= 1'b0;
            locked_q <= 1'b0;
            fault_q  <= 1'b0;
            revs_q   <= '0;
            errs_q   <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            o_q      <= o_d;
            wrap_q   <= wrap_d;
            locked_q <= locked_d;
            fault_q  <= fault_d;
            revs_q   <= revs_d;
            errs_q   <= errs_d;
        end
    end

    assign O      = o_q;
    assign PHASE  = phase_q;
    assign LOCKED = locked_q;
    assign WRAP   = wrap_q;
    assign FAULT  = fault_q;
    assign REVS   = revs_q;
    assign ERRS   = errs_q;

endmodule

// File: tb/tb_johnson4_phase_decoder.sv
// Scoreboard bench for johnson4_phase_decoder.
// Three instances: defaults, ALLOW_HOLD=0, and narrow counters (ERR_WIDTH=2, CNT_WIDTH=2).
module tb_johnson4_phase_decoder;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1;
    logic [3:0] i0 = '0, i1 = '0, i2 = '0;

    logic [7:0] o0, o1, o2;
    logic [2:0] ph0, ph1, ph2;
    logic       lk0, lk1, lk2, wr0, wr1, wr2, ft0, ft1, ft2;
    logic [7:0] rv0, rv1;
    logic [1:0] rv2;
    logic [3:0] er0, er1;
    logic [1:0] er2;

    johnson4_phase_decoder u_dut0 (
        .CLK(CLK), .RESET(rst0), .I(i0), .O(o0), .PHASE(ph0), .LOCKED(lk0),
        .WRAP(wr0), .REVS(rv0), .FAULT(ft0), .ERRS(er0)
    );

    johnson4_phase_decoder #(.ALLOW_HOLD(1'b0)) u_dut1 (
        .CLK(CLK), .RESET(rst1), .I(i1), .O(o1), .PHASE(ph1), .LOCKED(lk1),
        .WRAP(wr1), .REVS(rv1), .FAULT(ft1), .ERRS(er1)
    );

    johnson4_phase_decoder #(.CNT_WIDTH(2), .ERR_WIDTH(2)) u_dut2 (
        .CLK(CLK), .RESET(rst2), .I(i2), .O(o2), .PHASE(ph2), .LOCKED(lk2),
        .WRAP(wr2), .REVS(rv2), .FAULT(ft2), .ERRS(er2)
    );

    typedef struct {
        int         dut;
        logic [7:0] o;
        int         phase;
        bit         locked;
        bit         wrap;
        int         revs;
        bit         fault;
        int         errs;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [3:0] codes [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                              4'b1111, 4'b1110, 4'b1100, 4'b1000};

    // Monitor: every falling edge reflects the inputs sampled at the preceding rising edge.
    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [7:0] ao;
            int ap, ar, ae;
            bit al, aw, af;
            e = exp_q.pop_front();
            case (e.dut)
                0: begin ao = o0; ap = int'(ph0); al = lk0; aw = wr0; ar = int'(rv0); af = ft0; ae = int'(er0); end
                1: begin ao = o1; ap = int'(ph1); al = lk1; aw = wr1; ar = int'(rv1); af = ft1; ae = int'(er1); end
                default: begin ao = o2; ap = int'(ph2); al = lk2; aw = wr2; ar = int'(rv2); af = ft2; ae = int'(er2); end
            endcase
            n_tests++;
            if (ao !== e.o || ap != e.phase || al != e.locked || aw != e.wrap ||
                ar != e.revs || af != e.fault || ae != e.errs) begin
                n_fail++;
                $display("FAIL %s dut%0d: got O=%02h PHASE=%0d LOCKED=%0d WRAP=%0d REVS=%0d FAULT=%0d ERRS=%0d, want O=%02h PHASE=%0d LOCKED=%0d WRAP=%0d REVS=%0d FAULT=%0d ERRS=%0d",
                         e.name, e.dut, ao, ap, al, aw, ar, af, ae,
                         e.o, e.phase, e.locked, e.wrap, e.revs, e.fault, e.errs);
            end
        end
    end

    task automatic step(input int d, input logic rst, input logic [3:0] code,
                        input logic [7:0] eo, input int eph, input bit elk,
                        input bit ewr, input int erv, input bit eflt, input int eer,
                        input string name);
        exp_t e;
        @(negedge CLK);
        #1;
        case (d)
            0: begin rst0 = rst; i0 = code; end
            1: begin rst1 = rst; i1 = code; end
            default: begin rst2 = rst; i2 = code; end
        endcase
        e.dut = d; e.o = eo; e.phase = eph; e.locked = elk; e.wrap = ewr;
        e.revs = erv; e.fault = eflt; e.errs = eer; e.name = name;
        exp_q.push_back(e);
    endtask

    initial begin
        // ---------------- instance 0: defaults ----------------
        step(0, 1, 4'b0000, 8'h00, 0, 0, 0, 0, 0, 0, "reset");
        step(0, 1, 4'b0000, 8'h00, 0, 0, 0, 0, 0, 0, "reset");
        for (int r = 0; r < 3; r++)
            for (int p = 0; p < 8; p++)
                step(0, 0, codes[p], 8'(1 << p), p, 1, (p == 0 && r > 0), r, 0, 0, "clean_run");
        step(0, 0, 4'b0000, 8'h01, 0, 1, 1, 3, 0, 0, "wrap3");
        step(0, 0, 4'b0000, 8'h01, 0, 1, 0, 3, 0, 0, "hold_after_wrap");
        step(0, 0, 4'b0001, 8'h02, 1, 1, 0, 3, 0, 0, "advance");
        step(0, 0, 4'b0011, 8'h04, 2, 1, 0, 3, 0, 0, "advance");
        for (int k = 0; k < 4; k++)
            step(0, 0, 4'b0111, 8'h08, 3, 1, 0, 3, 0, 0, "hold_0111");
        step(0, 0, 4'b1111, 8'h10, 4, 1, 0, 3, 0, 0, "advance");
        step(0, 0, 4'b1110, 8'h20, 5, 1, 0, 3, 0, 0, "advance");
        step(0, 0, 4'b1100, 8'h40, 6, 1, 0, 3, 0, 0, "advance");
        step(0, 0, 4'b1000, 8'h80, 7, 1, 0, 3, 0, 0, "advance");
        step(0, 0, 4'b0000, 8'h01, 0, 1, 1, 4, 0, 0, "wrap4");
        step(0, 0, 4'b0001, 8'h02, 1, 1, 0, 4, 0, 0, "advance");
        step(0, 0, 4'b0011, 8'h04, 2, 1, 0, 4, 0, 0, "advance");
        step(0, 0, 4'b0101, 8'h00, 2, 0, 0, 4, 1, 1, "illegal_fault");
        step(0, 0, 4'b1100, 8'h00, 2, 0, 0, 4, 1, 1, "fault_stay_legal");
        step(0, 0, 4'b1001, 8'h00, 2, 0, 0, 4, 1, 1, "fault_stay_illegal");
        step(0, 0, 4'b0000, 8'h01, 0, 1, 0, 4, 0, 1, "fault_relock");
        step(0, 0, 4'b0001, 8'h02, 1, 1, 0, 4, 0, 1, "advance");
        step(0, 0, 4'b0111, 8'h00, 1, 0, 0, 4, 1, 2, "skip_fault");
        step(0, 0, 4'b0000, 8'h01, 0, 1, 0, 4, 0, 2, "fault_relock");
        step(0, 0, 4'b0001, 8'h02, 1, 1, 0, 4, 0, 2, "advance");
        step(0, 0, 4'b0011, 8'h04, 2, 1, 0, 4, 0, 2, "advance");
        step(0, 0, 4'b0111, 8'h08, 3, 1, 0, 4, 0, 2, "advance");
        step(0, 0, 4'b1111, 8'h10, 4, 1, 0, 4, 0, 2, "advance");
        step(0, 0, 4'b1110, 8'h20, 5, 1, 0, 4, 0, 2, "advance");
        step(0, 0, 4'b1100, 8'h40, 6, 1, 0, 4, 0, 2, "advance");
        step(0, 1, 4'b1000, 8'h00, 0, 0, 0, 0, 0, 0, "midrun_reset");
        step(0, 0, 4'b0101, 8'h00, 0, 0, 0, 0, 0, 1, "acquire_illegal");
        step(0, 0, 4'b1110, 8'h20, 5, 1, 0, 0, 0, 1, "acquire_lock_p5");
        step(0, 0, 4'b1100, 8'h40, 6, 1, 0, 0, 0, 1, "advance");
        step(0, 0, 4'b1000, 8'h80, 7, 1, 0, 0, 0, 1, "advance");
        step(0, 0, 4'b0000, 8'h01, 0, 1, 1, 1, 0, 1, "wrap_after_reset");

        // ---------------- instance 1: ALLOW_HOLD=0 ----------------
        step(1, 1, 4'b0000, 8'h00, 0, 0, 0, 0, 0, 0, "nohold_reset");
        step(1, 0, 4'b0000, 8'h01, 0, 1, 0, 0, 0, 0, "nohold_lock");
        step(1, 0, 4'b0001, 8'h02, 1, 1, 0, 0, 0, 0, "nohold_adv");
        step(1, 0, 4'b0011, 8'h04, 2, 1, 0, 0, 0, 0, "nohold_adv");
        step(1, 0, 4'b0111, 8'h08, 3, 1, 0, 0, 0, 0, "nohold_adv");
        step(1, 0, 4'b0111, 8'h00, 3, 0, 0, 0, 1, 1, "nohold_repeat_fault");
        step(1, 0, 4'b0111, 8'h00, 3, 0, 0, 0, 1, 1, "nohold_fault_stay");
        step(1, 0, 4'b0111, 8'h00, 3, 0, 0, 0, 1, 1, "nohold_fault_stay");
        step(1, 0, 4'b0000, 8'h01, 0, 1, 0, 0, 0, 1, "nohold_relock");

        // ---------------- instance 2: 2-bit counters ----------------
        step(2, 1, 4'b0000, 8'h00, 0, 0, 0, 0, 0, 0, "narrow_reset");
        for (int r = 0; r < 5; r++)
            for (int p = 0; p < 8; p++)
                step(2, 0, codes[p], 8'(1 << p), p, 1, (p == 0 && r > 0), r % 4, 0, 0, "narrow_run");
        step(2, 0, 4'b0000, 8'h01, 0, 1, 1, 1, 0, 0, "revs_wrap");
        for (int k = 1; k <= 5; k++) begin
            step(2, 0, 4'b0101, 8'h00, 0, 0, 0, 1, 1, (k < 3) ? k : 3, "errs_sat");
            step(2, 0, 4'b0000, 8'h01, 0, 1, 0, 1, 0, (k < 3) ? k : 3, "errs_sat_relock");
        end

        // drain the scoreboard with a bounded wait
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) @(negedge CLK);
        #2;
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expected responses left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
